// File: rtl/fpu_op_sequencer_if.sv
// Handshake and data bundle between the execute stage, the FPU datapath and
// the FP register-file write port, as seen by the op sequencer.
// Ports: master = execute/FPU side (drives op and result), slave = sequencer.
interface fpu_op_sequencer_if;
  // execute stage -> sequencer
  logic        op_valid;
  logic [2:0]  op_code;
  logic [4:0]  op_rd;
  logic        mem_wait;
  logic        flush;
  // FPU datapath -> sequencer
  logic [31:0] fpu_result_in;
  // sequencer -> FPU / pipeline / hazard unit / register file
  logic        unit_start;
  logic [2:0]  unit_sel;
  logic        stall;
  logic        busy;
  logic [4:0]  busy_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [31:0] perf_stall_cnt;

  modport master (
    output op_valid, op_code, op_rd, mem_wait, flush, fpu_result_in,
    input  unit_start, unit_sel, stall, busy, busy_rd,
           wb_valid, wb_rd, wb_data, illegal, perf_stall_cnt
  );

  modport slave (
    input  op_valid, op_code, op_rd, mem_wait, flush, fpu_result_in,
    output unit_start, unit_sel, stall, busy, busy_rd,
           wb_valid, wb_rd, wb_data, illegal, perf_stall_cnt
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Multi-cycle FP op sequencer: accepts one op, pulses unit_start, counts the
// unit latency while stalling the pipeline, then writes the result back.
// Latency: unit_start in T1, result sampled end of T(LAT), wb_valid in T(LAT+1).
// Backpressure: mem_wait freezes all state; flush kills an op in RUN.
// Ports: i_clk, i_rst (async active-low), io_seq (fpu_op_sequencer_if.slave).
// Option: define FPU_SEQ_PERF_EN to enable the stall-cycle counter.
module fpu_op_sequencer #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 16,
  parameter int SQRT_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fpu_op_sequencer_if.slave    io_seq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_lat;
  logic [2:0]         r_unit_sel;
  logic [4:0]         r_rd;
  logic [31:0]        r_wb_data;
  logic               r_unit_start;
  logic               r_illegal;
  logic               w_load;
  logic               w_capture;
  logic               w_can_issue;
  logic               w_accept;
  logic               w_illegal;
  logic               w_stall;

  // New ops are only considered when no op is counting down.
  assign w_can_issue = io_seq.op_valid & ~io_seq.flush & ~io_seq.mem_wait &
                       (r_state != S_RUN);
  assign w_accept    = w_can_issue & (io_seq.op_code <= 3'd4);
  assign w_illegal   = w_can_issue & (io_seq.op_code >  3'd4);

  always_comb begin
    w_lat = CNT_W'(ADD_LAT);
    case (io_seq.op_code)
      3'd0, 3'd1: w_lat = CNT_W'(ADD_LAT);
      3'd2:       w_lat = CNT_W'(MUL_LAT);
      3'd3:       w_lat = CNT_W'(DIV_LAT);
      3'd4:       w_lat = CNT_W'(SQRT_LAT);
      default:    w_lat = CNT_W'(ADD_LAT);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = w_lat;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (!io_seq.mem_wait) begin
          if (io_seq.flush) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_WB;
            w_capture   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      S_WB: begin
        // The write is already committed here, so flush has no effect.
        if (!io_seq.mem_wait) begin
          if (w_accept) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = w_lat;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_unit_sel   <= '0;
      r_rd         <= '0;
      r_wb_data    <= '0;
      r_unit_start <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      // w_load is a single-cycle event, so a later mem_wait cannot re-fire it.
      r_unit_start <= w_load;
      r_illegal    <= w_illegal;
      if (w_load) begin
        r_unit_sel <= io_seq.op_code;
        r_rd       <= io_seq.op_rd;
      end
      if (w_capture) begin
        r_wb_data <= io_seq.fpu_result_in;
      end
    end
  end

  // The kill cycle drops stall so the flushing pipeline can advance at once;
  // a concurrent mem_wait keeps the op (and the stall) alive.
  assign w_stall = ((r_state == S_RUN) & ~(io_seq.flush & ~io_seq.mem_wait)) |
                   w_accept;

  assign io_seq.stall      = w_stall;
  assign io_seq.busy       = (r_state == S_RUN);
  assign io_seq.busy_rd    = r_rd;
  assign io_seq.unit_start = r_unit_start;
  assign io_seq.unit_sel   = r_unit_sel;
  assign io_seq.wb_valid   = (r_state == S_WB);
  assign io_seq.wb_rd      = r_rd;
  assign io_seq.wb_data    = r_wb_data;
  assign io_seq.illegal    = r_illegal;

`ifdef FPU_SEQ_PERF_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_perf_cnt <= '0;
    end else if (w_stall) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign io_seq.perf_stall_cnt = r_perf_cnt;
`else
  assign io_seq.perf_stall_cnt = 32'd0;
`endif

endmodule
